// File: rtl/rca4s_chk.sv
// ============================================================================
//  Module      : rca4s_chk
//  Description : Checker for a 4-bit ripple-carry adder/subtractor. A run is
//                started with i_start; during the run up to NCHECK qualified
//                vectors are accepted. Each one is registered and compared
//                one cycle later against a reference {cout,sum}. Mismatches
//                are counted (saturating) and the first failure is kept.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              : clock, all state changes on the rising edge
//    rst              : asynchronous active-high reset
//    i_start          : single-cycle request to begin a run
//    i_valid          : qualifies i_a, i_b, i_subtract, i_sum, i_cout
//    i_a, i_b         : adder operands
//    i_subtract       : 0 = add, 1 = subtract
//    i_sum, i_cout    : result under test
//    o_busy           : high while a run is in progress
//    o_done           : high once the run has checked NCHECK vectors
//    o_pass           : done with zero mismatches
//    o_vec_count      : vectors checked in the current or last run
//    o_err_count      : mismatches in the current or last run (sat. at 255)
//    o_first_err_vec  : 0-based index of the first mismatching vector
//    o_first_err_exp  : expected {cout,sum} at the first mismatch
//    o_first_err_got  : observed {cout,sum} at the first mismatch
// ============================================================================
`default_nettype none

module rca4s_chk #(
  parameter int NCHECK = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_valid,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_subtract,
  input  logic [3:0] i_sum,
  input  logic       i_cout,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [7:0] o_vec_count,
  output logic [7:0] o_err_count,
  output logic [7:0] o_first_err_vec,
  output logic [4:0] o_first_err_exp,
  output logic [4:0] o_first_err_got
);

  localparam logic [7:0] c_ncheck = 8'(NCHECK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [7:0] r_acc_cnt;
  logic [7:0] r_vec_cnt;
  logic [7:0] r_err_cnt;
  logic [7:0] r_first_vec;
  logic [4:0] r_first_exp;
  logic [4:0] r_first_got;

  // Compare stage: one registered vector awaiting its check
  logic       r_cmp_vld;
  logic [3:0] r_cmp_a;
  logic [3:0] r_cmp_b;
  logic       r_cmp_sub;
  logic [4:0] r_cmp_got;

  logic       w_accept;
  logic [4:0] w_exp;
  logic       w_mismatch;
  logic [7:0] w_err_next;

  // Acceptance is bounded by the accept counter, not VecCount, so that
  // back-to-back vectors never overrun NCHECK while the last one is in flight.
  assign w_accept = (r_state == ST_RUN) && i_valid && (r_acc_cnt < c_ncheck);

  // Subtraction as A + ~B + 1 gives carry-out = 1 exactly when A >= B.
  assign w_exp = r_cmp_sub ? ({1'b0, r_cmp_a} + {1'b0, ~r_cmp_b} + 5'd1)
                           : ({1'b0, r_cmp_a} + {1'b0, r_cmp_b});

  assign w_mismatch = r_cmp_vld && (w_exp != r_cmp_got);
  assign w_err_next = (w_mismatch && (r_err_cnt != 8'hFF)) ? r_err_cnt + 8'd1
                                                           : r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_acc_cnt   <= 8'd0;
      r_vec_cnt   <= 8'd0;
      r_err_cnt   <= 8'd0;
      r_first_vec <= 8'd0;
      r_first_exp <= 5'd0;
      r_first_got <= 5'd0;
      r_cmp_vld   <= 1'b0;
      r_cmp_a     <= 4'd0;
      r_cmp_b     <= 4'd0;
      r_cmp_sub   <= 1'b0;
      r_cmp_got   <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // Outputs hold until a new run begins
          if (i_start) begin
            r_state     <= ST_RUN;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_acc_cnt   <= 8'd0;
            r_vec_cnt   <= 8'd0;
            r_err_cnt   <= 8'd0;
            r_first_vec <= 8'd0;
            r_first_exp <= 5'd0;
            r_first_got <= 5'd0;
            r_cmp_vld   <= 1'b0;
          end
        end

        ST_RUN: begin
          // i_start is deliberately not looked at here
          r_cmp_vld <= w_accept;
          if (w_accept) begin
            r_cmp_a   <= i_a;
            r_cmp_b   <= i_b;
            r_cmp_sub <= i_subtract;
            r_cmp_got <= {i_cout, i_sum};
            r_acc_cnt <= r_acc_cnt + 8'd1;
          end

          if (r_cmp_vld) begin
            r_vec_cnt <= r_vec_cnt + 8'd1;
            r_err_cnt <= w_err_next;
            if (w_mismatch && (r_err_cnt == 8'd0)) begin
              r_first_vec <= r_vec_cnt;
              r_first_exp <= w_exp;
              r_first_got <= r_cmp_got;
            end
            if ((r_vec_cnt + 8'd1) == c_ncheck) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == 8'd0);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_vec_count     = r_vec_cnt;
  assign o_err_count     = r_err_cnt;
  assign o_first_err_vec = r_first_vec;
  assign o_first_err_exp = r_first_exp;
  assign o_first_err_got = r_first_got;

endmodule

`default_nettype wire

// File: tb/tb_rca4s_chk.sv
// ============================================================================
//  Module      : tb_rca4s_chk
//  Description : Self-checking bench for rca4s_chk. Two instances share the
//                stimulus: one with NCHECK=4 and one with NCHECK=255.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rca4s_chk;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       sub = 1'b0;
  logic [3:0] sum = 4'd0;
  logic       cout = 1'b0;

  logic       busy4, done4, pass4;
  logic [7:0] vec4, err4, fvec4;
  logic [4:0] fexp4, fgot4;
  logic       busy255, done255, pass255;
  logic [7:0] vec255, err255, fvec255;
  logic [4:0] fexp255, fgot255;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rca4s_chk #(.NCHECK(4)) dut4 (
    .clk(clk), .rst(rst), .i_start(start), .i_valid(valid),
    .i_a(a), .i_b(b), .i_subtract(sub), .i_sum(sum), .i_cout(cout),
    .o_busy(busy4), .o_done(done4), .o_pass(pass4),
    .o_vec_count(vec4), .o_err_count(err4), .o_first_err_vec(fvec4),
    .o_first_err_exp(fexp4), .o_first_err_got(fgot4)
  );

  rca4s_chk #(.NCHECK(255)) dut255 (
    .clk(clk), .rst(rst), .i_start(start), .i_valid(valid),
    .i_a(a), .i_b(b), .i_subtract(sub), .i_sum(sum), .i_cout(cout),
    .o_busy(busy255), .o_done(done255), .o_pass(pass255),
    .o_vec_count(vec255), .o_err_count(err255), .o_first_err_vec(fvec255),
    .o_first_err_exp(fexp255), .o_first_err_got(fgot255)
  );

  // Reference: subtract result taken as difference mod 16 with borrow-free flag
  function automatic logic [4:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                       input logic msub);
    logic [3:0] d;
    if (msub) begin
      d = ma - mb;
      return {(ma >= mb), d};
    end
    return {1'b0, ma} + {1'b0, mb};
  endfunction

  // Advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vector for one cycle; bad=1 flips the carry-out
  task automatic send(input logic [3:0] va, input logic [3:0] vb,
                      input logic vs, input logic bad);
    logic [4:0] r;
    r = model(va, vb, vs);
    valid = 1'b1; a = va; b = vb; sub = vs;
    sum = r[3:0]; cout = r[4] ^ bad;
    step();
    valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_cmp++; if ({busy4, done4, pass4} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy4, done4, pass4}); end
    n_cmp++; if ({vec4, err4, fvec4, fexp4, fgot4} !== 34'd0) begin n_fail++; $display("FAIL reset_counts got %h want 0", {vec4, err4, fvec4, fexp4, fgot4}); end
    // Inputs ignored while reset is high
    start = 1'b1; valid = 1'b1;
    step();
    n_cmp++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_ignore_start got %b want 0", busy4); end
    start = 1'b0; valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    pulse_start();
    n_cmp++; if (busy4 !== 1'b1 || done4 !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b%b want 10", busy4, done4); end
    n_cmp++; if (model(4'd9, 4'd9, 1'b0) !== 5'b10010) begin n_fail++; $display("FAIL model_9p9 got %b want 10010", model(4'd9, 4'd9, 1'b0)); end
    send(4'd9, 4'd9, 1'b0, 1'b0);
    n_cmp++; if (vec4 !== 8'd0) begin n_fail++; $display("FAIL basic_latency got %0d want 0", vec4); end
    send(4'd15, 4'd1, 1'b0, 1'b0);
    n_cmp++; if (vec4 !== 8'd1) begin n_fail++; $display("FAIL basic_vec1 got %0d want 1", vec4); end
    send(4'd7, 4'd12, 1'b1, 1'b0);
    send(4'd12, 4'd7, 1'b1, 1'b0);
    n_cmp++; if (vec4 !== 8'd3 || busy4 !== 1'b1) begin n_fail++; $display("FAIL basic_vec3 got %0d/%b want 3/1", vec4, busy4); end
    step();
    n_cmp++; if ({done4, pass4, busy4} !== 3'b110) begin n_fail++; $display("FAIL basic_done got %b want 110", {done4, pass4, busy4}); end
    n_cmp++; if (vec4 !== 8'd4 || err4 !== 8'd0) begin n_fail++; $display("FAIL basic_counts got %0d/%0d want 4/0", vec4, err4); end
    // Outputs hold in DONE; Valid ignored
    send(4'd1, 4'd1, 1'b0, 1'b1);
    step();
    n_cmp++; if ({done4, pass4, vec4, err4} !== {2'b11, 8'd4, 8'd0}) begin n_fail++; $display("FAIL done_hold got %b%b/%0d/%0d want 11/4/0", done4, pass4, vec4, err4); end
  endtask

  task automatic test_subtract();
    pulse_start();
    n_cmp++; if (done4 !== 1'b0 || vec4 !== 8'd0) begin n_fail++; $display("FAIL sub_restart got %b/%0d want 0/0", done4, vec4); end
    send(4'd3, 4'd5, 1'b1, 1'b0);   // 01110 is correct
    send(4'd3, 4'd5, 1'b1, 1'b1);   // 11110 is wrong
    n_cmp++; if (err4 !== 8'd0) begin n_fail++; $display("FAIL sub_correct got %0d want 0", err4); end
    send(4'd0, 4'd0, 1'b1, 1'b0);
    n_cmp++; if (err4 !== 8'd1 || fexp4 !== 5'b01110 || fgot4 !== 5'b11110) begin n_fail++; $display("FAIL sub_first got %0d/%b/%b want 1/01110/11110", err4, fexp4, fgot4); end
    send(4'd15, 4'd15, 1'b0, 1'b0);
    step();
    n_cmp++; if ({done4, pass4, fvec4} !== {2'b10, 8'd1}) begin n_fail++; $display("FAIL sub_done got %b%b/%0d want 10/1", done4, pass4, fvec4); end
  endtask

  task automatic test_errors();
    pulse_start();
    send(4'd2, 4'd3, 1'b0, 1'b0);
    send(4'd8, 4'd8, 1'b0, 1'b1);   // index 1, exp 10000
    send(4'd5, 4'd1, 1'b1, 1'b0);
    send(4'd1, 4'd5, 1'b1, 1'b1);   // index 3
    step();
    n_cmp++; if (err4 !== 8'd2 || fvec4 !== 8'd1) begin n_fail++; $display("FAIL err_counts got %0d/%0d want 2/1", err4, fvec4); end
    n_cmp++; if (fexp4 !== 5'b10000 || fgot4 !== 5'b00000) begin n_fail++; $display("FAIL err_first got %b/%b want 10000/00000", fexp4, fgot4); end
    n_cmp++; if ({done4, pass4} !== 2'b10 || vec4 !== 8'd4) begin n_fail++; $display("FAIL err_done got %b/%0d want 10/4", {done4, pass4}, vec4); end
  endtask

  task automatic test_gaps();
    pulse_start();
    send(4'd1, 4'd2, 1'b0, 1'b0);
    step();
    n_cmp++; if (vec4 !== 8'd1) begin n_fail++; $display("FAIL gap_vec1 got %0d want 1", vec4); end
    pulse_start();                  // ignored in RUN
    n_cmp++; if (vec4 !== 8'd1 || busy4 !== 1'b1) begin n_fail++; $display("FAIL gap_start_run got %0d/%b want 1/1", vec4, busy4); end
    send(4'd6, 4'd9, 1'b1, 1'b0);
    step(); step();
    send(4'd14, 4'd3, 1'b0, 1'b0);
    send(4'd10, 4'd4, 1'b1, 1'b0);
    n_cmp++; if (vec4 !== 8'd3 || done4 !== 1'b0) begin n_fail++; $display("FAIL gap_pre_done got %0d/%b want 3/0", vec4, done4); end
    // Extra vector together with Start on the final compare cycle
    start = 1'b1;
    send(4'd1, 4'd1, 1'b0, 1'b1);
    start = 1'b0;
    n_cmp++; if ({done4, busy4, vec4} !== {2'b10, 8'd4}) begin n_fail++; $display("FAIL gap_done got %b/%0d want 10/4", {done4, busy4}, vec4); end
    send(4'd1, 4'd1, 1'b0, 1'b1);
    step();
    n_cmp++; if ({done4, busy4, pass4, vec4, err4} !== {3'b101, 8'd4, 8'd0}) begin n_fail++; $display("FAIL gap_extras got %b/%0d/%0d want 101/4/0", {done4, busy4, pass4}, vec4, err4); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send(4'd4, 4'd4, 1'b0, 1'b1);
    send(4'd5, 4'd4, 1'b0, 1'b1);
    n_cmp++; if (vec4 !== 8'd1 || err4 !== 8'd1) begin n_fail++; $display("FAIL mid_pre got %0d/%0d want 1/1", vec4, err4); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if ({busy4, done4, vec4, err4, fgot4} !== 23'd0) begin n_fail++; $display("FAIL mid_async got %h want 0", {busy4, done4, vec4, err4, fgot4}); end
    step();
    rst = 1'b0;
    valid = 1'b1;
    step(); step();
    valid = 1'b0;
    n_cmp++; if (busy4 !== 1'b0 || vec4 !== 8'd0) begin n_fail++; $display("FAIL mid_idle got %b/%0d want 0/0", busy4, vec4); end
    pulse_start();
    send(4'd0, 4'd15, 1'b0, 1'b0);
    send(4'd15, 4'd0, 1'b1, 1'b0);
    send(4'd8, 4'd9, 1'b1, 1'b0);
    send(4'd11, 4'd11, 1'b1, 1'b0);
    step();
    n_cmp++; if ({done4, pass4, vec4, err4} !== {2'b11, 8'd4, 8'd0}) begin n_fail++; $display("FAIL mid_clean got %b/%0d/%0d want 11/4/0", {done4, pass4}, vec4, err4); end
  endtask

  task automatic test_saturate();
    rst = 1'b1;
    step();
    rst = 1'b0;
    pulse_start();
    for (int i = 0; i < 260; i++) send(4'(i), 4'(i >> 4), 1'(i >> 2), 1'b1);
    step();
    n_cmp++; if (err255 !== 8'd255 || vec255 !== 8'd255) begin n_fail++; $display("FAIL sat_counts got %0d/%0d want 255/255", err255, vec255); end
    n_cmp++; if ({done255, pass255, busy255} !== 3'b100 || fvec255 !== 8'd0) begin n_fail++; $display("FAIL sat_done got %b/%0d want 100/0", {done255, pass255, busy255}, fvec255); end
    n_cmp++; if (fexp255 !== 5'b00000 || fgot255 !== 5'b10000) begin n_fail++; $display("FAIL sat_first got %b/%b want 00000/10000", fexp255, fgot255); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_subtract();
    test_errors();
    test_gaps();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
